// File: rtl/demon_readback_pkg.sv
// Shared constants and state encoding for the sample-RAM readback engine.
package demon_readback_pkg;
   localparam int ADDR_W_DEF = 13;
   localparam int CNT_W_DEF  = 14;
   localparam int FIFO_DEPTH = 2;
   localparam int WORD_W     = 9;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Occupancy of the two-entry buffer from its flags.
   function automatic logic [2:0] occupancy(input logic full, input logic empty);
      return full ? 3'd2 : (empty ? 3'd0 : 3'd1);
   endfunction
endpackage

// File: rtl/readback_fifo2.sv
// Two-entry word buffer between the sample RAM and the output stream; flush empties it.
module readback_fifo2
   import demon_readback_pkg::*;
#(
   parameter int W = WORD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   logic [FIFO_DEPTH-1:0][W-1:0] mem;
   logic                         wr_ptr, rd_ptr;
   logic [1:0]                   cnt;
   logic                         do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == 2'(FIFO_DEPTH));
   assign empty = (cnt == 2'd0);
endmodule

// File: rtl/sample_readback.sv
// Streams COUNT words from the sample RAM starting at START_ADDR through a 2-entry buffer.
// Optional SAMPLE_READBACK_REVERSE_EN adds a REVERSE input selecting descending addresses.
module sample_readback
   import demon_readback_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [ADDR_W-1:0] START_ADDR,
   input  logic [CNT_W-1:0]  COUNT,
   input  logic              ABORT,
`ifdef SAMPLE_READBACK_REVERSE_EN
   input  logic              REVERSE,
`endif
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] RAM_ADDR,
   output logic              RAM_EN,
   output logic              RAM_WE,
   input  logic [7:0]        RAM_DOUT,
   input  logic              RAM_DOUTP,
   output logic [7:0]        OUT_DATA,
   output logic              OUT_DATAP,
   output logic              OUT_VALID,
   input  logic              OUT_READY
);
   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr;
   logic [CNT_W-1:0]    remaining;
   logic                inflight, zero_done;
   logic                fifo_full, fifo_empty, pop, issue, launch;
   logic [WORD_W-1:0]   fifo_dout;
   logic [2:0]          pending;
`ifdef SAMPLE_READBACK_REVERSE_EN
   logic                rev;
`endif

   assign launch = (state == ST_IDLE) && START && !ABORT && (COUNT != '0);
   assign pop    = OUT_VALID & OUT_READY;
   // Words buffered plus in flight after this cycle's pop; issue only if room remains.
   assign pending = occupancy(fifo_full, fifo_empty) + {2'b0, inflight} - {2'b0, pop};
   assign issue   = (state == ST_RUN) && !ABORT && (pending < 3'd2);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (ABORT) state_nxt = ST_IDLE;
      else begin
         case (state)
            ST_IDLE:  if (launch) state_nxt = ST_RUN;
            ST_RUN:   if (issue && remaining == CNT_W'(1)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !inflight) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      BUSY   = (state != ST_IDLE);
      RAM_EN = issue;
      DONE   = !ABORT && (zero_done || (state == ST_DRAIN && fifo_empty && !inflight));
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         addr      <= '0;
         remaining <= '0;
         inflight  <= 1'b0;
         zero_done <= 1'b0;
`ifdef SAMPLE_READBACK_REVERSE_EN
         rev       <= 1'b0;
`endif
      end else begin
         inflight  <= issue;
         zero_done <= (state == ST_IDLE) && START && !ABORT && (COUNT == '0);
         if (launch) begin
            addr      <= START_ADDR;
            remaining <= COUNT;
`ifdef SAMPLE_READBACK_REVERSE_EN
            rev       <= REVERSE;
`endif
         end else if (issue) begin
`ifdef SAMPLE_READBACK_REVERSE_EN
            addr      <= rev ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
`else
            addr      <= addr + ADDR_W'(1);
`endif
            remaining <= remaining - CNT_W'(1);
         end
      end
   end

   // Abort flushes the buffer and drops the word returning from a read already issued.
   readback_fifo2 #(.W(WORD_W)) u_fifo (
      .clk   (CLK),
      .rst   (RESET),
      .flush (ABORT),
      .push  (inflight & ~ABORT),
      .pop   (pop),
      .din   ({RAM_DOUTP, RAM_DOUT}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign RAM_ADDR               = addr;
   assign RAM_WE                 = 1'b0;
   assign OUT_VALID              = ~fifo_empty;
   assign {OUT_DATAP, OUT_DATA}  = fifo_empty ? '0 : fifo_dout;
endmodule

// File: tb/tb_sample_readback.sv
// Directed bench for sample_readback with a one-cycle-latency RAM model and a stream monitor.
module tb_sample_readback;
   localparam int AW = 13;
   localparam int CW = 14;

   logic          CLK = 1'b0;
   logic          RESET, START, ABORT, OUT_READY, RAM_DOUTP;
   logic [AW-1:0] START_ADDR;
   logic [CW-1:0] COUNT;
   logic [7:0]    RAM_DOUT;
`ifdef SAMPLE_READBACK_REVERSE_EN
   logic          REVERSE;
`endif
   logic          BUSY, DONE, RAM_EN, RAM_WE, OUT_DATAP, OUT_VALID;
   logic [AW-1:0] RAM_ADDR;
   logic [7:0]    OUT_DATA;

   sample_readback #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR), .COUNT(COUNT),
      .ABORT(ABORT),
`ifdef SAMPLE_READBACK_REVERSE_EN
      .REVERSE(REVERSE),
`endif
      .BUSY(BUSY), .DONE(DONE), .RAM_ADDR(RAM_ADDR), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE),
      .RAM_DOUT(RAM_DOUT), .RAM_DOUTP(RAM_DOUTP), .OUT_DATA(OUT_DATA), .OUT_DATAP(OUT_DATAP),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
   );

   always #5 CLK = ~CLK;

   function automatic logic [8:0] ram_word(input logic [AW-1:0] a);
      logic [7:0] d;
      d = a[7:0] ^ {a[12:8], 3'b101};
      return {^d, d};
   endfunction

   always @(posedge CLK) if (RAM_EN) {RAM_DOUTP, RAM_DOUT} <= ram_word(RAM_ADDR);

   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   logic [AW-1:0] exp_addr[$];
   logic [AW-1:0] last_rd_addr;
   int  cyc = 0, issued = 0, xfers = 0, dones = 0;
   int  last_rd = 0, last_xf = 0, first_rd = 0, first_xf = 0, done_cyc = 0, start_cyc = 0;
   bit  mon_en = 0, b2b = 0;
   logic       pv = 1'b0, pr = 1'b0;
   logic [8:0] pd = '0;

   // Inputs change on the falling edge; the monitor looks 2 ns later.
   always @(negedge CLK) begin
      #2;
      cyc++;
      if (mon_en) begin
         if (OUT_VALID && OUT_READY) begin
            if (xfers < exp_addr.size()) chk("word", {OUT_DATAP, OUT_DATA}, ram_word(exp_addr[xfers]));
            else chk("extra_word", 1, 0);
            if (b2b && xfers > 0) chk("xf_b2b", cyc - last_xf, 1);
            if (xfers == 0) first_xf = cyc;
            last_xf = cyc;
            xfers++;
         end
         if (RAM_EN) begin
            chk("ram_we", RAM_WE, 0);
            if (issued < exp_addr.size()) chk("rd_addr", RAM_ADDR, exp_addr[issued]);
            else chk("extra_rd", 1, 0);
            if (b2b && issued > 0) chk("rd_b2b", cyc - last_rd, 1);
            if (issued == 0) first_rd = cyc;
            last_rd      = cyc;
            last_rd_addr = RAM_ADDR;
            issued++;
            chk("outstanding_le2", (issued - xfers) <= 2, 1);
         end
         if (pv && !pr && OUT_VALID) chk("stall_hold", {OUT_DATAP, OUT_DATA}, pd);
         if (DONE) begin
            dones++;
            done_cyc = cyc;
         end
      end
      pv = OUT_VALID;
      pr = OUT_READY;
      pd = {OUT_DATAP, OUT_DATA};
   end

   task automatic start_xfer(input logic [AW-1:0] a, input logic [CW-1:0] n, input bit rev);
      exp_addr.delete();
      for (int i = 0; i < int'(n); i++) exp_addr.push_back(rev ? a - AW'(i) : a + AW'(i));
      issued = 0;
      xfers  = 0;
      @(negedge CLK);
      START = 1'b1; START_ADDR = a; COUNT = n;
`ifdef SAMPLE_READBACK_REVERSE_EN
      REVERSE = rev;
`endif
      start_cyc = cyc + 1;
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget, input bit rand_ready);
      int d0 = dones;
      int k  = 0;
      while (dones == d0 && k < budget) begin
         @(negedge CLK);
         if (rand_ready) OUT_READY = 1'($urandom_range(0, 1));
         k++;
      end
      OUT_READY = 1'b1;
      chk({tag, "_done_seen"}, dones - d0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0;
      int k;
      RESET = 1'b1; START = 1'b0; ABORT = 1'b0; OUT_READY = 1'b1;
      START_ADDR = '0; COUNT = '0; RAM_DOUT = '0; RAM_DOUTP = 1'b0;
`ifdef SAMPLE_READBACK_REVERSE_EN
      REVERSE = 1'b0;
`endif
      repeat (2) @(negedge CLK);
      #3;
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_ram_en", RAM_EN, 0);
      chk("rst_ram_we", RAM_WE, 0);
      chk("rst_ram_addr", RAM_ADDR, 0);
      chk("rst_valid", OUT_VALID, 0);
      chk("rst_data", {OUT_DATAP, OUT_DATA}, 0);
      @(negedge CLK);
      RESET  = 1'b0;
      mon_en = 1'b1;

      // Basic streaming, full throughput
      b2b = 1'b1;
      start_xfer(13'h010, 4, 1'b0);
      wait_done("t1", 40, 1'b0);
      b2b = 1'b0;
      chk("t1_reads", issued, 4);
      chk("t1_words", xfers, 4);
      chk("t1_first_rd", first_rd - start_cyc, 1);
      chk("t1_rd_to_out", first_xf - first_rd >= 2, 1);
      chk("t1_done_lat", done_cyc - last_xf, 1);
      #3 chk("t1_idle", BUSY, 0);

      // Address wrap at top of RAM
      start_xfer(13'h1FFE, 4, 1'b0);
      wait_done("t2", 40, 1'b0);
      chk("t2_words", xfers, 4);
      chk("t2_last_addr", last_rd_addr, 13'h0001);

      // Random backpressure
      start_xfer(13'h0A5, 16, 1'b0);
      wait_done("t3", 400, 1'b1);
      chk("t3_reads", issued, 16);
      chk("t3_words", xfers, 16);

      // Abort mid-transfer, then restart
      start_xfer(13'h100, 10, 1'b0);
      k = 0;
      while (xfers < 3 && k < 50) begin
         @(negedge CLK);
         k++;
      end
      chk("t4_reached3", xfers >= 3, 1);
      d0    = dones;
      ABORT = 1'b1;
      @(negedge CLK);
      ABORT = 1'b0;
      #3;
      chk("t4_valid_low", OUT_VALID, 0);
      chk("t4_busy_low", BUSY, 0);
      repeat (5) @(negedge CLK);
      chk("t4_no_done", dones - d0, 0);
      start_xfer(13'h020, 5, 1'b0);
      wait_done("t4b", 40, 1'b0);
      chk("t4b_words", xfers, 5);

      // Zero-length request
      d0 = dones;
      start_xfer(13'h055, 0, 1'b0);
      #3;
      chk("t5_done", DONE, 1);
      chk("t5_busy", BUSY, 0);
      repeat (4) @(negedge CLK);
      chk("t5_no_read", issued, 0);
      chk("t5_one_done", dones - d0, 1);

      // Reset mid-transfer
      start_xfer(13'h300, 10, 1'b0);
      repeat (3) @(negedge CLK);
      d0    = dones;
      RESET = 1'b1;
      #3;
      chk("t6_busy", BUSY, 0);
      chk("t6_valid", OUT_VALID, 0);
      chk("t6_ram_en", RAM_EN, 0);
      chk("t6_ram_addr", RAM_ADDR, 0);
      @(negedge CLK);
      RESET = 1'b0;
      repeat (6) @(negedge CLK);
      chk("t6_no_done", dones - d0, 0);

`ifdef SAMPLE_READBACK_REVERSE_EN
      // Descending addresses with wrap below zero
      start_xfer(13'h0001, 3, 1'b1);
      wait_done("t7", 40, 1'b0);
      chk("t7_words", xfers, 3);
      chk("t7_last_addr", last_rd_addr, 13'h1FFF);
`endif

      repeat (2) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
